vec_inst_queue: RTL and testbench
=================================

Name: vec_inst_queue

Overview:
- Instruction issue buffer between the scalar processor and the vector datapath.
- Accepts vector instructions with their rs1/rs2 scalar operands through a valid/ready handshake and holds them in a FIFO.
- Presents the head entry to the datapath and keeps it stable until the datapath reports completion on inst_done, or until the decoder rejects it on is_vec=0.
- Only one instruction is in flight at a time.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- XLEN, 32, width of the instruction and scalar operand fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- inst_valid  input  1  scalar processor offers an instruction.
- instruction  input  XLEN  offered instruction word.
- rs1_data  input  XLEN  scalar operand for rs1.
- rs2_data  input  XLEN  scalar operand for rs2.
- inst_ready  output  1  queue can accept; high when count<DEPTH.
- flush  input  1  synchronous clear of queue and FSM.
- issue_valid  output  1  head entry is presented to the datapath.
- issue_inst  output  XLEN  head instruction to the datapath.
- issue_rs1  output  XLEN  head rs1 operand.
- issue_rs2  output  XLEN  head rs2 operand.
- is_vec  input  1  decoder legality of issue_inst; combinational from issue_inst.
- inst_done  input  1  datapath completion pulse (regfile write or CSR done).
- retire  output  1  one-cycle pulse: head completed and popped.
- illegal  output  1  one-cycle pulse: head rejected as non-vector and popped.
- count  output  $clog2(DEPTH+1)  current occupancy, including the in-flight entry.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - count=0; read and write pointers = 0; FSM=IDLE.
  - issue_valid=0, retire=0, illegal=0, busy=0.
  - issue_inst/rs1/rs2 = 0; inst_ready=1.
  - Reset mid-execution discards the in-flight entry silently; no retire pulse.
- Push: when inst_valid && inst_ready, {instruction, rs1_data, rs2_data} is written at wr_ptr, which then increments modulo DEPTH.
- No bypass: a pushed entry is presented no earlier than the cycle after the push.
- inst_ready is combinational from count, and is low when count==DEPTH even if a pop occurs in the same cycle.
- Pop: on retire or illegal, rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: count is unchanged.
- Pointers wrap with an extra wrap bit; full and empty are derived from count.
- FSM states:
  - IDLE: issue_valid=0. If count>0, go to ISSUE next cycle.
  - ISSUE: issue_valid=1, head fields driven from the rd_ptr entry.
    - is_vec=0: pulse illegal next cycle, pop, go to IDLE.
    - is_vec=1 and inst_done=1: pulse retire, pop, go to IDLE.
    - Otherwise go to EXEC.
  - EXEC: issue_valid=1, head fields held stable. On inst_done: retire, pop, go to IDLE.
- Issue latency: back-to-back instructions have one IDLE cycle between them; minimum issue period is 2 cycles.
- Pulse timing: retire and illegal are registered and assert in the cycle after the completing edge condition.
- inst_done and is_vec are ignored in IDLE.
- Between issues: issue_inst/rs1/rs2 hold the last presented values while issue_valid=0; consumers must qualify with issue_valid.
- flush:
  - Next cycle: count=0, pointers=0, FSM=IDLE, issue_valid=0, no retire pulse.
  - A push in the same cycle as flush is dropped.
  - flush has priority over push, pop and inst_done.
- busy = (FSM != IDLE).
- count never exceeds DEPTH and never underflows.

Test Plan:
- Reset then idle:
  - Push instruction 0x0200_7057 (vsetvli) with rs1=16, rs2=0.
  - Expect issue_valid=1 two cycles after push with issue_inst=0x0200_7057 and issue_rs1=16.
  - Drive inst_done 3 cycles later: retire pulse, count returns to 0.
- Fill to DEPTH=4 with no inst_done:
  - inst_ready=0 at count=4; a 5th inst_valid is not accepted.
  - After one inst_done, inst_ready=1 and the 5th push is accepted.
  - Issued order matches push order, including across pointer wrap.
- Head with is_vec=0 (instruction 0x0000_0013):
  - illegal pulses, no retire, next entry issued.
  - inst_done asserted while IDLE has no effect.
- Push and pop in the same cycle at count=2 -> count stays 2; inst_done in the ISSUE cycle -> retire without entering EXEC.
- flush during EXEC with 3 entries plus a simultaneous push -> next cycle count=0, issue_valid=0, no retire, pushed entry absent.
- Assert n_rst low during EXEC -> all outputs are zero immediately (asynchronous) and inst_ready=1 after release.

Source files
------------

// File: rtl/vec_inst_queue.sv
// Issue buffer between the scalar core and the vector datapath: FIFO of
// {instruction, rs1, rs2} with a one-in-flight IDLE/ISSUE/EXEC issue FSM.
module vec_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       inst_valid,
  input  logic [XLEN-1:0]            instruction,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  output logic                       inst_ready,
  input  logic                       flush,
  output logic                       issue_valid,
  output logic [XLEN-1:0]            issue_inst,
  output logic [XLEN-1:0]            issue_rs1,
  output logic [XLEN-1:0]            issue_rs2,
  input  logic                       is_vec,
  input  logic                       inst_done,
  output logic                       retire,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned PTRW = PW + 1;
  localparam int unsigned EW   = 3 * XLEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   head_q, head_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic            issue_valid_q, issue_valid_d;
  logic            retire_q, retire_d;
  logic            illegal_q, illegal_d;
  logic            busy_q, busy_d;
  logic            push, pop, load_head;

  assign inst_ready = (count_q < CW'(DEPTH));
  assign push       = inst_valid && inst_ready && !flush;

  // Issue FSM; flush overrides every transition and suppresses pulses.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    load_head = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = ISSUE;
          load_head = 1'b1;
        end
      end
      ISSUE: begin
        if (!is_vec) begin
          illegal_d = 1'b1;
          pop       = 1'b1;
          state_d   = IDLE;
        end else if (inst_done) begin
          retire_d = 1'b1;
          pop      = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (inst_done) begin
          retire_d = 1'b1;
          pop      = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      pop       = 1'b0;
      retire_d  = 1'b0;
      illegal_d = 1'b0;
      load_head = 1'b0;
    end
  end

  // Pointer/occupancy bookkeeping and head capture.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (load_head) head_d = mem_q[rd_ptr_q[PW-1:0]];
    issue_valid_d = (state_d != IDLE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {instruction, rs1_data, rs2_data};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_q        <= '0;
      issue_valid_q <= 1'b0;
      retire_q      <= 1'b0;
      illegal_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_q        <= head_d;
      issue_valid_q <= issue_valid_d;
      retire_q      <= retire_d;
      illegal_q     <= illegal_d;
      busy_q        <= busy_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_inst  = head_q[EW-1 -: XLEN];
  assign issue_rs1   = head_q[2*XLEN-1 -: XLEN];
  assign issue_rs2   = head_q[XLEN-1:0];
  assign retire      = retire_q;
  assign illegal     = illegal_q;
  assign count       = count_q;
  assign busy        = busy_q;

  // Wrap-bit pointer distance must always equal the occupancy counter.
  a_ptr_count: assert property (@(posedge clk) disable iff (!n_rst)
    CW'(wr_ptr_q - rd_ptr_q) == count_q);
  a_count_max: assert property (@(posedge clk) disable iff (!n_rst)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_vec_inst_queue.sv
// Bench for vec_inst_queue: directed scenarios plus random traffic, checked by a
// queue-based reference model in a negedge monitor.
module tb_vec_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            n_rst = 1'b1;
  logic            inst_valid, flush, is_vec, inst_done;
  logic [XLEN-1:0] instruction, rs1_data, rs2_data;
  logic            inst_ready, issue_valid, retire, illegal, busy;
  logic [XLEN-1:0] issue_inst, issue_rs1, issue_rs2;
  logic [2:0]      count;

  always #5 clk = ~clk;

  // Decoder stand-in: only the OP-V major opcode is a legal vector instruction.
  assign is_vec = (issue_inst[6:0] == 7'h57);

  vec_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .n_rst(n_rst), .inst_valid(inst_valid), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .inst_ready(inst_ready), .flush(flush),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .is_vec(is_vec), .inst_done(inst_done), .retire(retire),
    .illegal(illegal), .count(count), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] i;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  ent_t        model_q[$];
  bit          exp_ret, exp_ill, prev_iv, prev_ne, prev_flush;
  logic [31:0] held_i, held_a, held_b;
  int          sz;

  // Reference model: ordered list of accepted entries; the head leaves when it
  // is presented and either rejected or completed, unless flush wins.
  always @(negedge clk) begin
    if (!n_rst) begin
      model_q.delete();
      exp_ret = 0; exp_ill = 0; prev_iv = 0; prev_ne = 0; prev_flush = 0;
    end else begin
      sz = model_q.size();
      chk("count", 32'(count), 32'(sz));
      chk("inst_ready", 32'(inst_ready), 32'(sz < DEPTH));
      chk("retire", 32'(retire), 32'(exp_ret));
      chk("illegal", 32'(illegal), 32'(exp_ill));
      chk("busy", 32'(busy), 32'(issue_valid));
      if (issue_valid && !prev_iv) begin
        chk("issue_nonempty", 32'(sz != 0), 32'(1));
        if (sz != 0) begin
          chk("issue_inst", issue_inst, model_q[0].i);
          chk("issue_rs1", issue_rs1, model_q[0].a);
          chk("issue_rs2", issue_rs2, model_q[0].b);
          held_i = model_q[0].i; held_a = model_q[0].a; held_b = model_q[0].b;
        end else begin
          held_i = issue_inst; held_a = issue_rs1; held_b = issue_rs2;
        end
      end else if (issue_valid) begin
        chk("hold_inst", issue_inst, held_i);
        chk("hold_rs1", issue_rs1, held_a);
        chk("hold_rs2", issue_rs2, held_b);
      end
      if (prev_ne && !prev_iv && !prev_flush && sz > 0)
        chk("issue_latency", 32'(issue_valid), 32'(1));
      prev_iv    = issue_valid;
      prev_ne    = (sz > 0);
      prev_flush = flush;
      if (flush) begin
        model_q.delete();
        exp_ret = 0; exp_ill = 0;
      end else begin
        if (issue_valid && (!is_vec || inst_done)) begin
          exp_ret = is_vec;
          exp_ill = !is_vec;
          if (sz > 0) void'(model_q.pop_front());
        end else begin
          exp_ret = 0; exp_ill = 0;
        end
        if (inst_valid && inst_ready) model_q.push_back('{instruction, rs1_data, rs2_data});
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive_push(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    inst_valid = 1'b1; instruction = i; rs1_data = a; rs2_data = b;
    cyc();
    inst_valid = 1'b0;
  endtask

  task automatic wait_issue(input string name);
    for (int k = 0; k < 20 && !issue_valid; k++) @(negedge clk);
    chk(name, 32'(issue_valid), 32'(1));
  endtask

  task automatic drain(input string name);
    inst_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (count == 0 && !issue_valid) break;
      inst_done = 1'($urandom_range(0, 1));
      cyc();
    end
    inst_done = 1'b0;
    @(negedge clk);
    chk(name, 32'(count), 32'(0));
  endtask

  initial begin
    int ill_seen, ret_seen;
    inst_valid = 0; instruction = 0; rs1_data = 0; rs2_data = 0; flush = 0; inst_done = 0;
    #1 n_rst = 1'b0;
    #2;
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_inst_ready", 32'(inst_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_issue_inst", issue_inst, 0);
    #19 n_rst = 1'b1;
    cyc();

    // Single vsetvli: issue two cycles after push, retire after inst_done.
    drive_push(32'h0200_7057, 32'd16, 32'd0);
    @(negedge clk);
    chk("no_bypass", 32'(issue_valid), 0);
    @(negedge clk);
    chk("t1_issue_valid", 32'(issue_valid), 1);
    chk("t1_issue_inst", issue_inst, 32'h0200_7057);
    chk("t1_issue_rs1", issue_rs1, 32'd16);
    chk("t1_issue_rs2", issue_rs2, 32'd0);
    chk("t1_busy", 32'(busy), 1);
    cyc(); cyc(); cyc();
    inst_done = 1'b1;
    cyc();
    inst_done = 1'b0;
    @(negedge clk);
    chk("t1_retire", 32'(retire), 1);
    chk("t1_count", 32'(count), 0);

    // Fill to DEPTH; fifth offer stalls until a pop, then wraps the pointers.
    for (int k = 0; k < 4; k++) begin
      inst_valid = 1'b1;
      instruction = 32'h1000_0057 + 32'(k << 12);
      rs1_data = $urandom; rs2_data = $urandom;
      cyc();
    end
    instruction = 32'h1000_5057; rs1_data = $urandom; rs2_data = $urandom;
    @(negedge clk);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(inst_ready), 0);
    @(negedge clk); @(negedge clk);
    chk("full_hold_count", 32'(count), 4);
    inst_done = 1'b1;
    @(posedge clk); #1;
    inst_done = 1'b0;
    @(negedge clk);
    chk("after_pop_count", 32'(count), 3);
    chk("after_pop_ready", 32'(inst_ready), 1);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    @(negedge clk);
    chk("fifth_accepted", 32'(count), 4);
    drain("t2_drain");

    // Non-vector head is rejected; inst_done held high while idle is ignored.
    inst_done = 1'b1;
    cyc();
    drive_push(32'h0000_0013, $urandom, $urandom);
    drive_push(32'h00A0_7057, $urandom, $urandom);
    ill_seen = 0; ret_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ill_seen += int'(illegal);
      ret_seen += int'(retire);
    end
    inst_done = 1'b0;
    chk("t3_illegal_pulses", 32'(ill_seen), 1);
    chk("t3_retire_pulses", 32'(ret_seen), 1);
    chk("t3_count", 32'(count), 0);

    // Simultaneous push and pop at count=2, then retire straight from ISSUE.
    drive_push(32'hA000_0057, $urandom, $urandom);
    drive_push(32'hB000_0057, $urandom, $urandom);
    @(negedge clk); @(negedge clk);
    inst_valid = 1'b1; instruction = 32'hC000_0057; rs1_data = $urandom; rs2_data = $urandom;
    inst_done = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0; inst_done = 1'b0;
    @(negedge clk);
    chk("push_pop_count", 32'(count), 2);
    chk("push_pop_retire", 32'(retire), 1);
    wait_issue("t4_issue_b");
    inst_done = 1'b1;
    @(posedge clk); #1;
    inst_done = 1'b0;
    @(negedge clk);
    chk("issue_retire", 32'(retire), 1);
    chk("issue_retire_busy", 32'(busy), 0);
    drain("t4_drain");

    // Flush during EXEC with a same-cycle push.
    drive_push(32'hD100_0057, $urandom, $urandom);
    drive_push(32'hD200_0057, $urandom, $urandom);
    drive_push(32'hD300_0057, $urandom, $urandom);
    @(negedge clk);
    chk("pre_flush_count", 32'(count), 3);
    chk("pre_flush_valid", 32'(issue_valid), 1);
    flush = 1'b1; inst_valid = 1'b1; instruction = 32'hDEAD_0057;
    @(posedge clk); #1;
    flush = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(issue_valid), 0);
    chk("flush_retire", 32'(retire), 0);
    chk("flush_busy", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_push_absent", 32'(issue_valid), 0);
    end

    // Asynchronous reset during EXEC.
    drive_push(32'hE100_0057, 32'h1111, 32'h2222);
    drive_push(32'hE200_0057, 32'h3333, 32'h4444);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_valid", 32'(issue_valid), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_valid", 32'(issue_valid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_retire", 32'(retire), 0);
    chk("arst_illegal", 32'(illegal), 0);
    chk("arst_inst", issue_inst, 0);
    chk("arst_rs1", issue_rs1, 0);
    chk("arst_rs2", issue_rs2, 0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(inst_ready), 1);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_valid", 32'(issue_valid), 0);

    // Random traffic against the model.
    cyc();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      inst_valid  = 1'($urandom_range(0, 1));
      instruction = {r[31:7], ($urandom_range(0, 4) == 0) ? 7'h13 : 7'h57};
      rs1_data    = $urandom;
      rs2_data    = $urandom;
      inst_done   = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      cyc();
    end
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
